// File: rtl/map_layer_scheduler.sv
// Layer-buffer sequencer between game control and the block generator.
// Fills a circular buffer on start and replaces the bottom layer on each scroll.
module map_layer_scheduler #(
  parameter int unsigned LAYERS      = 4,
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned GEN_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        generate_map,
  output logic                        layer_req,
  input  logic                        load_layer,
  input  logic [WIDTH-1:0]            layer_map,
  input  logic [WIDTH-1:0]            block_type,
  input  logic                        scroll_req,
  output logic                        scroll_ack,
  input  logic [$clog2(LAYERS)-1:0]   rd_idx,
  output logic [WIDTH-1:0]            rd_map,
  output logic [WIDTH-1:0]            rd_type,
  output logic                        map_valid,
  output logic                        busy,
  output logic                        error,
  output logic [15:0]                 scrolled
);

  localparam int unsigned IW = $clog2(LAYERS);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(GEN_TIMEOUT + 1);
  localparam int unsigned SW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_READY,
    S_SCROLL,
    S_WAIT,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] map;
    logic [WIDTH-1:0] btype;
  } layer_t;

  state_t        state_q;
  state_t        state_d;
  layer_t        buf_q [LAYERS];
  logic [IW-1:0] head_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] tmo_q;

  logic          wr_en;
  logic          ptr_clear;
  logic          ptr_scroll;
  logic          tmo_clear;
  logic          tmo_inc;
  logic          scroll_done;
  logic          busy_d;
  logic [IW-1:0] wr_slot;
  logic [IW-1:0] rd_slot;
  layer_t        wr_layer;

  // Physical slots: writes land just above the current top, reads are head-relative.
  assign wr_slot  = head_q + count_q[IW-1:0];
  assign rd_slot  = head_q + rd_idx;
  assign wr_layer = '{map: layer_map, btype: block_type};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    ptr_clear   = 1'b0;
    ptr_scroll  = 1'b0;
    tmo_clear   = 1'b0;
    tmo_inc     = 1'b0;
    scroll_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        ptr_clear = 1'b1;
        tmo_clear = 1'b1;
        state_d   = S_FILL;
      end
      S_FILL: begin
        if (load_layer) begin
          wr_en     = 1'b1;
          tmo_clear = 1'b1;
          if (count_q == CW'(LAYERS - 1)) state_d = S_READY;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_q == TW'(GEN_TIMEOUT - 1)) state_d = S_ERROR;
        end
      end
      S_READY: begin
        if (start) begin
          state_d = S_REQ;
        end else if (scroll_req) begin
          state_d = S_SCROLL;
        end
      end
      S_SCROLL: begin
        ptr_scroll = 1'b1;
        tmo_clear  = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (load_layer) begin
          wr_en       = 1'b1;
          tmo_clear   = 1'b1;
          scroll_done = 1'b1;
          state_d     = S_READY;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_q == TW'(GEN_TIMEOUT - 1)) state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        if (start) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = !(state_d inside {S_IDLE, S_READY, S_ERROR});

  // Head/count bookkeeping; a scroll drops the bottom layer by advancing head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      count_q <= '0;
    end else if (ptr_clear) begin
      head_q  <= '0;
      count_q <= '0;
    end else if (ptr_scroll) begin
      head_q  <= head_q + IW'(1);
      count_q <= CW'(LAYERS - 1);
    end else if (wr_en) begin
      count_q <= count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (tmo_clear) begin
      tmo_q <= '0;
    end else if (tmo_inc) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LAYERS); i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_slot] <= wr_layer;
    end
  end

  // Registered outputs follow the state being entered, so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      generate_map <= 1'b0;
      layer_req    <= 1'b0;
      scroll_ack   <= 1'b0;
      map_valid    <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      scrolled     <= '0;
      rd_map       <= '0;
      rd_type      <= '0;
    end else begin
      generate_map <= (state_d == S_REQ);
      layer_req    <= (state_d == S_SCROLL);
      scroll_ack   <= scroll_done;
      map_valid    <= (state_d == S_READY);
      busy         <= busy_d;
      error        <= (state_d == S_ERROR);
      if (scroll_done) scrolled <= scrolled + SW'(1);
      rd_map       <= buf_q[rd_slot].map;
      rd_type      <= buf_q[rd_slot].btype;
    end
  end

endmodule

// File: tb/tb_map_layer_scheduler.sv
// Directed bench for map_layer_scheduler with a queue-based reference model
// checked every falling edge, plus literal expectations along the scenarios.
module tb_map_layer_scheduler;

  localparam int unsigned LAYERS      = 4;
  localparam int unsigned WIDTH       = 7;
  localparam int unsigned GEN_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             generate_map;
  logic             layer_req;
  logic             load_layer = 1'b0;
  logic [WIDTH-1:0] layer_map = '0;
  logic [WIDTH-1:0] block_type = '0;
  logic             scroll_req = 1'b0;
  logic             scroll_ack;
  logic [1:0]       rd_idx = '0;
  logic [WIDTH-1:0] rd_map;
  logic [WIDTH-1:0] rd_type;
  logic             map_valid;
  logic             busy;
  logic             error;
  logic [15:0]      scrolled;

  int errors = 0;
  int checks = 0;

  map_layer_scheduler #(
    .LAYERS(LAYERS), .WIDTH(WIDTH), .GEN_TIMEOUT(GEN_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .generate_map(generate_map),
    .layer_req(layer_req), .load_layer(load_layer), .layer_map(layer_map),
    .block_type(block_type), .scroll_req(scroll_req), .scroll_ack(scroll_ack),
    .rd_idx(rd_idx), .rd_map(rd_map), .rd_type(rd_type), .map_valid(map_valid),
    .busy(busy), .error(error), .scrolled(scrolled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: logical layer list (bottom first) plus sequencing phase.
  typedef enum int {M_IDLE, M_GEN, M_FILL, M_READY, M_SCROLL, M_WAIT, M_ERR} mphase_t;
  mphase_t     ph = M_IDLE;
  logic [13:0] lay[$];
  int          idle_cnt = 0;
  int          m_scrolled = 0;
  bit          m_ack = 1'b0;
  bit          m_rd_ok = 1'b1;
  logic [6:0]  m_rd_map = '0;
  logic [6:0]  m_rd_type = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = M_IDLE; lay.delete(); idle_cnt = 0; m_scrolled = 0;
      m_ack = 1'b0; m_rd_ok = 1'b1; m_rd_map = '0; m_rd_type = '0;
    end else begin
      m_rd_ok = int'(rd_idx) < lay.size();
      if (m_rd_ok) begin
        m_rd_map  = lay[rd_idx][13:7];
        m_rd_type = lay[rd_idx][6:0];
      end
      m_ack = 1'b0;
      case (ph)
        M_IDLE:   if (start) ph = M_GEN;
        M_GEN:    begin lay.delete(); idle_cnt = 0; ph = M_FILL; end
        M_FILL: begin
          if (load_layer) begin
            lay.push_back({layer_map, block_type});
            idle_cnt = 0;
            if (lay.size() == int'(LAYERS)) ph = M_READY;
          end else begin
            idle_cnt++;
            if (idle_cnt >= int'(GEN_TIMEOUT)) ph = M_ERR;
          end
        end
        M_READY: begin
          if (start) ph = M_GEN;
          else if (scroll_req) ph = M_SCROLL;
        end
        M_SCROLL: begin void'(lay.pop_front()); idle_cnt = 0; ph = M_WAIT; end
        M_WAIT: begin
          if (load_layer) begin
            lay.push_back({layer_map, block_type});
            m_scrolled = (m_scrolled + 1) % 65536;
            m_ack = 1'b1;
            ph = M_READY;
          end else begin
            idle_cnt++;
            if (idle_cnt >= int'(GEN_TIMEOUT)) ph = M_ERR;
          end
        end
        M_ERR: if (start) ph = M_GEN;
        default: ph = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("generate_map", 32'(generate_map), 32'(ph == M_GEN));
    chk("layer_req", 32'(layer_req), 32'(ph == M_SCROLL));
    chk("map_valid", 32'(map_valid), 32'(ph == M_READY));
    chk("busy", 32'(busy), 32'(ph inside {M_GEN, M_FILL, M_SCROLL, M_WAIT}));
    chk("error", 32'(error), 32'(ph == M_ERR));
    chk("scroll_ack", 32'(scroll_ack), 32'(m_ack));
    chk("scrolled", 32'(scrolled), 32'(m_scrolled));
    if (m_rd_ok) begin
      chk("rd_map", 32'(rd_map), 32'(m_rd_map));
      chk("rd_type", 32'(rd_type), 32'(m_rd_type));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [6:0] m, input logic [6:0] t);
    load_layer = 1'b1; layer_map = m; block_type = t;
    step();
    load_layer = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lit_gen_high", 32'(generate_map), 32'd1);
    step();
    chk("lit_gen_one_pulse", 32'(generate_map), 32'd0);
  endtask

  task automatic read(input int i, input logic [6:0] em, input logic [6:0] et);
    rd_idx = 2'(i);
    step();
    chk("lit_rd_map", 32'(rd_map), 32'(em));
    chk("lit_rd_type", 32'(rd_type), 32'(et));
  endtask

  task automatic read_all();
    for (int i = 0; i < int'(LAYERS); i++) begin
      rd_idx = 2'(i);
      step();
    end
  endtask

  task automatic fill_std();
    load(7'b0001000, 7'b0000000);
    load(7'b1010101, 7'b1000101);
    load(7'b0101010, 7'b0001010);
    chk("lit_valid_before_last", 32'(map_valid), 32'd0);
    load(7'b1010101, 7'b0010101);
    chk("lit_valid_after_last", 32'(map_valid), 32'd1);
  endtask

  task automatic do_scroll(input logic [6:0] m, input logic [6:0] t, input int gap, input bit poke);
    scroll_req = 1'b1;
    step();
    scroll_req = 1'b0;
    chk("lit_layer_req_high", 32'(layer_req), 32'd1);
    chk("lit_valid_low_scroll", 32'(map_valid), 32'd0);
    step();
    chk("lit_layer_req_one_pulse", 32'(layer_req), 32'd0);
    for (int i = 0; i < gap; i++) begin
      scroll_req = poke;
      step();
      scroll_req = 1'b0;
    end
    load(m, t);
    chk("lit_scroll_ack_high", 32'(scroll_ack), 32'd1);
    chk("lit_valid_after_scroll", 32'(map_valid), 32'd1);
    step();
    chk("lit_scroll_ack_one_pulse", 32'(scroll_ack), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    step(); step();
    chk("lit_reset_outputs", 32'({generate_map, layer_req, scroll_ack, map_valid, busy, error}), 32'd0);
    chk("lit_reset_scrolled", 32'(scrolled), 32'd0);
    rst = 1'b1;
    step();

    // Initial fill and ordered read-back.
    pulse_start();
    fill_std();
    read(0, 7'b0001000, 7'b0000000);
    read(1, 7'b1010101, 7'b1000101);
    read(2, 7'b0101010, 7'b0001010);
    read(3, 7'b1010101, 7'b0010101);

    // First scroll.
    do_scroll(7'b1111111, 7'b0000001, 0, 1'b0);
    chk("lit_scrolled_1", 32'(scrolled), 32'd1);
    read(0, 7'b1010101, 7'b1000101);
    read(3, 7'b1111111, 7'b0000001);

    // Four more scrolls wrap the head; one with scroll_req poked during the wait.
    do_scroll(7'h0F, 7'h70, 0, 1'b0); read_all();
    do_scroll(7'h33, 7'h4C, 3, 1'b1); read_all();
    do_scroll(7'h55, 7'h2A, 1, 1'b0); read_all();
    do_scroll(7'h1E, 7'h61, 0, 1'b0); read_all();
    chk("lit_scrolled_5", 32'(scrolled), 32'd5);
    read(0, 7'h0F, 7'h70);
    read(3, 7'h1E, 7'h61);

    // Generator timeout after two layers.
    pulse_start();
    load(7'h01, 7'h02);
    load(7'h03, 7'h04);
    repeat (15) step();
    chk("lit_error_not_yet", 32'(error), 32'd0);
    step();
    chk("lit_error_set", 32'(error), 32'd1);
    chk("lit_error_valid_low", 32'(map_valid), 32'd0);
    chk("lit_error_not_busy", 32'(busy), 32'd0);
    repeat (3) step();
    pulse_start();
    chk("lit_error_cleared", 32'(error), 32'd0);
    fill_std();
    chk("lit_recover_error", 32'(error), 32'd0);

    // start and scroll_req together: refill wins.
    start = 1'b1; scroll_req = 1'b1;
    step();
    start = 1'b0; scroll_req = 1'b0;
    chk("lit_both_gen", 32'(generate_map), 32'd1);
    chk("lit_both_no_layer_req", 32'(layer_req), 32'd0);
    step();
    fill_std();
    chk("lit_both_scrolled", 32'(scrolled), 32'd5);

    // Asynchronous reset in the middle of a fill.
    pulse_start();
    load(7'h11, 7'h22);
    load(7'h33, 7'h44);
    #2 rst = 1'b0;
    #1;
    chk("lit_async_outputs", 32'({generate_map, layer_req, scroll_ack, map_valid, busy, error}), 32'd0);
    chk("lit_async_scrolled", 32'(scrolled), 32'd0);
    chk("lit_async_rd", 32'({rd_map, rd_type}), 32'd0);
    step();
    rst = 1'b1;
    rd_idx = 2'd0;
    load(7'h7F, 7'h7F);
    load(7'h7F, 7'h7F);
    load(7'h7F, 7'h7F);
    chk("lit_idle_loads_valid", 32'(map_valid), 32'd0);
    chk("lit_idle_loads_busy", 32'(busy), 32'd0);
    chk("lit_idle_rd_cleared", 32'({rd_map, rd_type}), 32'd0);
    pulse_start();
    fill_std();
    read(0, 7'b0001000, 7'b0000000);
    read(2, 7'b0101010, 7'b0001010);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
